// File: rtl/umi_pkg.sv
// Shared UMI request definitions: default field widths and the request-entry layout.
// The entry order (cmd, dstaddr, srcaddr, data) is the storage order used by the request buffer.
package umi_pkg;

  localparam int UMI_DW = 256;
  localparam int UMI_AW = 64;
  localparam int UMI_CW = 32;

  localparam logic [31:0] ACC_CNT_MAX = 32'hFFFF_FFFF;

  // Default-width entry; modules with overridden widths declare the same layout locally.
  typedef struct packed {
    logic [UMI_CW-1:0] cmd;
    logic [UMI_AW-1:0] dstaddr;
    logic [UMI_AW-1:0] srcaddr;
    logic [UMI_DW-1:0] data;
  } umi_req_t;

  function automatic int umi_entry_w(input int cw, input int aw, input int dw);
    return cw + 2 * aw + dw;
  endfunction

endpackage

// File: rtl/umi_req_buffer_mem.sv
// Request storage array: one synchronous write port, one asynchronous read port.
// Write data lands at the rising edge; read data follows rd_addr combinationally, contents are never reset.
module umi_req_buffer_mem #(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = 416,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/umi_req_buffer.sv
// FIFO buffer for UMI requests heading to a memory device; one cycle from push to out_valid, no bypass.
// in_ready is simply !full, so a full buffer refuses input even when a pop happens in the same cycle.
module umi_req_buffer
  import umi_pkg::*;
#(
  parameter int DW    = UMI_DW,
  parameter int AW    = UMI_AW,
  parameter int CW    = UMI_CW,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CW-1:0]            in_cmd,
  input  logic [AW-1:0]            in_dstaddr,
  input  logic [AW-1:0]            in_srcaddr,
  input  logic [DW-1:0]            in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CW-1:0]            out_cmd,
  output logic [AW-1:0]            out_dstaddr,
  output logic [AW-1:0]            out_srcaddr,
  output logic [DW-1:0]            out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [31:0]              accepted_cnt
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int EW = umi_entry_w(CW, AW, DW);

  typedef struct packed {
    logic [CW-1:0] cmd;
    logic [AW-1:0] dstaddr;
    logic [AW-1:0] srcaddr;
    logic [DW-1:0] data;
  } req_t;

  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [31:0]   acc_cnt_q;
  logic          push;
  logic          pop;
  req_t          wr_entry;
  req_t          rd_entry;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign count = wr_ptr_q - rd_ptr_q;

  assign in_ready  = !full;
  assign out_valid = !empty;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      acc_cnt_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (push && (acc_cnt_q != ACC_CNT_MAX)) begin
        acc_cnt_q <= acc_cnt_q + 32'd1;
      end
    end
  end

  assign accepted_cnt = acc_cnt_q;

  assign wr_entry.cmd     = in_cmd;
  assign wr_entry.dstaddr = in_dstaddr;
  assign wr_entry.srcaddr = in_srcaddr;
  assign wr_entry.data    = in_data;

  // Write is gated by rst so a push in the reset cycle leaves no trace.
  umi_req_buffer_mem #(
    .DEPTH  (DEPTH),
    .WIDTH  (EW),
    .ADDR_W (PW - 1)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push && !rst),
    .wr_addr (wr_ptr_q[PW-2:0]),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr_q[PW-2:0]),
    .rd_data (rd_entry)
  );

  assign out_cmd     = rd_entry.cmd;
  assign out_dstaddr = rd_entry.dstaddr;
  assign out_srcaddr = rd_entry.srcaddr;
  assign out_data    = rd_entry.data;

endmodule

// File: tb/tb_umi_req_buffer.sv
// Scoreboard bench for umi_req_buffer: driver queues accepted requests, monitor checks every output transfer.
module tb_umi_req_buffer;

  localparam int DW    = 256;
  localparam int AW    = 64;
  localparam int CW    = 32;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [CW-1:0] cmd;
    logic [AW-1:0] dstaddr;
    logic [AW-1:0] srcaddr;
    logic [DW-1:0] data;
  } req_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [CW-1:0]          in_cmd;
  logic [AW-1:0]          in_dstaddr;
  logic [AW-1:0]          in_srcaddr;
  logic [DW-1:0]          in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [CW-1:0]          out_cmd;
  logic [AW-1:0]          out_dstaddr;
  logic [AW-1:0]          out_srcaddr;
  logic [DW-1:0]          out_data;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   empty;
  logic [31:0]            accepted_cnt;

  int   asserts = 0;
  int   fails   = 0;
  req_t exp_q[$];

  always #5 clk = ~clk;

  umi_req_buffer #(.DW(DW), .AW(AW), .CW(CW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_cmd       (in_cmd),
    .in_dstaddr   (in_dstaddr),
    .in_srcaddr   (in_srcaddr),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_cmd      (out_cmd),
    .out_dstaddr  (out_dstaddr),
    .out_srcaddr  (out_srcaddr),
    .out_data     (out_data),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .accepted_cnt (accepted_cnt)
  );

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; record acceptance just before the rising edge.
  task automatic drive_cycle(input logic v, input req_t e, input logic ordy, input logic r);
    @(negedge clk);
    rst        = r;
    in_valid   = v;
    in_cmd     = e.cmd;
    in_dstaddr = e.dstaddr;
    in_srcaddr = e.srcaddr;
    in_data    = e.data;
    out_ready  = ordy;
    #4;
    if (r) exp_q.delete();
    else if (in_valid && in_ready) exp_q.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic req_t mk(input int i);
    req_t e;
    e.cmd     = CW'(i + 1);
    e.dstaddr = AW'(64'h1000 + i);
    e.srcaddr = AW'(64'h2000 + i);
    e.data    = {8{32'(i) ^ 32'hA5A5_0000}};
    return e;
  endfunction

  function automatic req_t rnd_req();
    req_t e;
    e.cmd     = $urandom;
    e.dstaddr = {$urandom, $urandom};
    e.srcaddr = {$urandom, $urandom};
    e.data    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return e;
  endfunction

  // Monitor: compares each output transfer with the scoreboard and checks stall stability.
  logic stall_prev = 1'b0;
  req_t prev_out;
  always begin
    req_t got;
    req_t e;
    @(negedge clk);
    #4;
    got = {out_cmd, out_dstaddr, out_srcaddr, out_data};
    if (!rst && stall_prev) check("out_stable", got, prev_out);
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        asserts++;
        fails++;
        $display("FAIL sb_underflow: got output transfer %0h, expected none", got);
      end else begin
        e = exp_q.pop_front();
        check("out_fields", got, e);
      end
    end
    stall_prev = !rst && out_valid && !out_ready;
    prev_out   = got;
  end

  initial begin
    req_t e1;
    req_t re;
    int   acc;
    int   cyc;
    logic v;
    logic ordy;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_cmd = '0; in_dstaddr = '0; in_srcaddr = '0; in_data = '0;

    // Reset state
    drive_cycle(1'b0, '0, 1'b0, 1'b1);
    drive_cycle(1'b0, '0, 1'b0, 1'b1);
    after_edge();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_accepted", accepted_cnt, 0);

    // Single request, no same-cycle bypass
    e1 = '0;
    e1.cmd = 32'h5;
    e1.dstaddr = 64'h100;
    e1.data = 256'hAB;
    drive_cycle(1'b1, e1, 1'b1, 1'b0);
    check("single_no_bypass", out_valid, 0);
    after_edge();
    check("single_out_valid", out_valid, 1);
    check("single_count1", count, 1);
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    after_edge();
    check("single_count0", count, 0);
    check("single_empty", empty, 1);

    // Fill to full, 5th request refused
    drive_cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, mk(i), 1'b0, 1'b0);
    after_edge();
    check("fill_full", full, 1);
    check("fill_in_ready", in_ready, 0);
    check("fill_count", count, 4);
    drive_cycle(1'b1, mk(4), 1'b0, 1'b0);
    after_edge();
    check("fill5_count", count, 4);
    check("fill5_accepted", accepted_cnt, 4);

    // Full with simultaneous pop: pop only, then push next cycle
    drive_cycle(1'b1, mk(4), 1'b1, 1'b0);
    after_edge();
    check("fullpop_count", count, 3);
    check("fullpop_accepted", accepted_cnt, 4);
    drive_cycle(1'b1, mk(4), 1'b0, 1'b0);
    after_edge();
    check("fullpush_count", count, 4);
    check("fullpush_accepted", accepted_cnt, 5);
    repeat (6) drive_cycle(1'b0, '0, 1'b1, 1'b0);
    after_edge();
    check("drain1_empty", empty, 1);
    check("drain1_sb_left", exp_q.size(), 0);

    // Random traffic: order, wrap and stall stability
    acc = 0;
    cyc = 0;
    re  = rnd_req();
    v   = 1'b0;
    while (acc < 100 && cyc < 3000) begin
      if (!v) begin
        v  = 1'($urandom_range(0, 1));
        re = rnd_req();
      end
      ordy = 1'($urandom_range(0, 1));
      drive_cycle(v, re, ordy, 1'b0);
      if (v && in_ready) begin
        acc++;
        v = 1'b0;
      end
      cyc++;
    end
    check("rand_all_accepted", acc, 100);
    repeat (8) drive_cycle(1'b0, '0, 1'b1, 1'b0);
    after_edge();
    check("rand_sb_left", exp_q.size(), 0);
    check("rand_count", count, 0);

    // Reset mid-flight drops entries and discards the simultaneous push/pop
    drive_cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, mk(10 + i), 1'b0, 1'b0);
    after_edge();
    check("mid_count3", count, 3);
    drive_cycle(1'b1, mk(20), 1'b1, 1'b1);
    after_edge();
    check("mid_empty", empty, 1);
    check("mid_count", count, 0);
    check("mid_accepted", accepted_cnt, 0);
    check("mid_out_valid", out_valid, 0);
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    after_edge();
    check("mid_still_empty", empty, 1);

    // Saturation of accepted_cnt
    @(negedge clk);
    force dut.acc_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.acc_cnt_q;
    drive_cycle(1'b1, mk(30), 1'b1, 1'b0);
    after_edge();
    check("sat_first", accepted_cnt, 32'hFFFF_FFFF);
    drive_cycle(1'b1, mk(31), 1'b1, 1'b0);
    drive_cycle(1'b1, mk(32), 1'b1, 1'b0);
    after_edge();
    check("sat_hold", accepted_cnt, 32'hFFFF_FFFF);
    repeat (4) drive_cycle(1'b0, '0, 1'b1, 1'b0);
    after_edge();
    check("final_sb_left", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/umi_req_buffer.md
UMI_REQ_BUFFER -- requirements
Module: umi_req_buffer

Interface
REQ-001 Parameter DW, default 256, data width in bits.
REQ-002 Parameter AW, default 64, address width in bits.
REQ-003 Parameter CW, default 32, command width in bits.
REQ-004 Parameter DEPTH, default 4, entry count; power of 2, at least 2.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid/in_ready  input/output  1/1  upstream request handshake.
REQ-008 in_cmd/in_dstaddr/in_srcaddr/in_data  input  CW/AW/AW/DW  upstream request fields.
REQ-009 out_valid/out_ready  output/input  1/1  downstream request handshake to the memory device.
REQ-010 out_cmd/out_dstaddr/out_srcaddr/out_data  output  CW/AW/AW/DW  downstream request fields.
REQ-011 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-012 full/empty  output  1/1  occupancy flags.
REQ-013 accepted_cnt  output  32  saturating count of accepted requests.

Function
REQ-014 Transfers SHALL occur only on a rising edge where valid and ready are both 1 on the same side.
REQ-015 in_ready SHALL equal !full and SHALL NOT depend combinationally on out_ready or in_valid.
REQ-016 An accepted request SHALL store cmd, dstaddr, srcaddr and data as one entry in FIFO order.
REQ-017 Latency: an entry written into an empty buffer at edge N SHALL drive out_valid=1 after edge N, with no same-cycle bypass.
REQ-018 out_valid SHALL equal !empty, and out_* fields SHALL show the oldest entry.
REQ-019 While out_valid=1 and out_ready=0, all out_* fields SHALL hold stable.
REQ-020 Simultaneous push and pop at the same edge SHALL leave count unchanged and preserve order.
REQ-021 When full, in_valid SHALL be ignored even if out_ready=1 in the same cycle, because in_ready=0.
REQ-022 When empty, out_ready SHALL be ignored.
REQ-023 Read and write pointers SHALL be $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
REQ-024 full SHALL be 1 when the pointer MSBs differ and the lower bits are equal; empty SHALL be 1 when the pointers are equal.
REQ-025 count SHALL equal the write pointer minus the read pointer, modulo 2*DEPTH, with a range of 0..DEPTH.
REQ-026 accepted_cnt SHALL increment by 1 per input transfer and saturate at 0xFFFFFFFF.

Reset
REQ-027 When rst=1 at an edge, both pointers SHALL become 0.
REQ-028 After that edge, out_valid=0, in_ready=1, count=0, full=0, empty=1 and accepted_cnt=0.
REQ-029 Reset SHALL override any simultaneous handshake; a push or pop in the rst=1 cycle SHALL be discarded.
REQ-030 Storage contents SHALL NOT be reset; out_* data fields are don't-care while out_valid=0.
REQ-031 Reset asserted mid-operation SHALL drop all buffered entries, with no output transfer in the following cycle.

Structure
REQ-032 Package umi_pkg SHALL hold the default DW/AW/CW constants and a parameterized request-entry packed struct (cmd, dstaddr, srcaddr, data).
REQ-033 Storage SHALL be one sub-module umi_req_buffer_mem: DEPTH x (CW+2*AW+DW), one write port and one asynchronous read port.
REQ-034 Pointer, flag and counter logic SHALL reside in umi_req_buffer.

Verification
REQ-035 Single request: push cmd=0x5, dstaddr=0x100, data=0xAB, out_ready=1 -> out_valid rises the next cycle with identical fields, then count returns to 0.
REQ-036 Fill: 4 pushes with out_ready=0 -> full=1, in_ready=0, count=4; a 5th in_valid is not accepted and accepted_cnt=4.
REQ-037 Full with simultaneous traffic: buffer full, in_valid=1, out_ready=1 for one cycle -> one pop and no push, so count=3; next cycle the push is accepted and count=4.
REQ-038 Wrap and order: 100 random requests with random in_valid/out_ready -> output sequence equals input sequence, and out_* is stable whenever stalled.
REQ-039 Reset mid-flight: 3 entries held, rst=1 for one cycle while in_valid=1 -> empty=1, count=0, accepted_cnt=0 and out_valid=0 the next cycle.
REQ-040 Saturation: force accepted_cnt=0xFFFFFFFE, then do 3 pushes -> accepted_cnt=0xFFFFFFFF.
